rca_result_accumulator: RTL and testbench
=========================================

Name: rca_result_accumulator

Overview:
- Downstream consumer of the N-bit ripple carry adder (RippleCarryAdder_nBit).
- Captures each adder result {cout, sum} through a valid/ready handshake and accumulates the results into a wider running total.
- Counts accepted samples and carry-out events; stops after a programmed number of samples.
- Used to build multi-sample sums and carry statistics from the combinational adder.

Parameters:
- N, 4, width of the adder sum input (matches the adder's N).
- ACC_W, 12, accumulator width; must be at least N+1.
- CNT_W, 8, width of the sample-count and carry-count fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a new accumulation run; acted on in IDLE or DONE only.
- num_samples  input  CNT_W  number of samples to accept; sampled when start is accepted.
- in_valid  input  1  sum/cout hold a valid adder result.
- in_ready  output  1  block will accept a result this cycle.
- sum  input  N  adder sum.
- cout  input  1  adder carry-out.
- acc  output  ACC_W  running total.
- sample_cnt  output  CNT_W  results accepted in the current run.
- carry_cnt  output  CNT_W  accepted results with cout=1.
- overflow  output  1  sticky flag: the accumulator exceeded 2^ACC_W-1 during the run.
- busy  output  1  high in ACCUM.
- done  output  1  high in DONE.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Reset:
- Asynchronous on rst_n low. State goes to IDLE.
- acc, sample_cnt, carry_cnt = 0; overflow, busy, done, in_ready = 0.
- Reset mid-run abandons the run. No partial results are retained.

State machine (IDLE, ACCUM, DONE), registered:
- IDLE, start=1, num_samples>0: clear acc, sample_cnt, carry_cnt, overflow; latch num_samples; go to ACCUM.
- IDLE, start=1, num_samples=0: clear the same registers; go straight to DONE.
- ACCUM: in_ready=1 (driven from state only, never from in_valid).
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - On each transfer: acc <= acc + zero_extend({cout,sum}) (an N+1-bit value, 0..2^(N+1)-1); sample_cnt += 1; carry_cnt += cout.
  - Transfer with sample_cnt+1 == latched count: go to DONE at the same edge.
  - start is ignored in ACCUM.
  - No transfer occurs while in_valid=0; all registers hold.
- DONE: done=1, in_ready=0; outputs are held.
  - start=1 restarts exactly as from IDLE.
  - There is no automatic return to IDLE.

Timing:
- Latency: acc, sample_cnt and carry_cnt show a transfer's effect in the cycle after the accepting edge.
- done rises in the cycle after the final transfer.

Width rules:
- acc wraps modulo 2^ACC_W. A carry out of bit ACC_W-1 sets overflow, which stays set until the next start or reset.
- sample_cnt cannot exceed num_samples, so it never overflows.
- carry_cnt cannot exceed sample_cnt.

Handshake:
- in_valid asserted in IDLE or DONE is never consumed.
- The upstream source must hold sum/cout stable while in_valid=1 and in_ready=0.

Optional Feature:
- Macro: RCA_ACC_SATURATE_EN.
- Defined: acc saturates at 2^ACC_W-1 instead of wrapping. overflow is still set on the first saturating transfer; acc stays at all-ones for the rest of the run.
- Not defined: modulo wrap as described above.

Test Plan:
1. Reset, then start with num_samples=3; feed {cout,sum}=(0,5),(1,3),(0,15) on consecutive cycles -> acc=39, sample_cnt=3, carry_cnt=1, overflow=0; done=1 one cycle after the 3rd transfer; in_ready=0 afterwards.
2. Feed the same values with in_valid gaps of 2 idle cycles between samples -> identical final values; registers hold during the gaps.
3. num_samples=133, every sample (1,15)=31 -> wrap build: acc=27, overflow=1, carry_cnt=133. With RCA_ACC_SATURATE_EN defined: acc=4095, overflow=1.
4. Corner cases:
   - start with num_samples=0 -> DONE next cycle, acc=0, no transfers.
   - in_valid held high in IDLE -> in_ready=0 and no counts change.
5. Drop rst_n low mid-run after 2 of 5 samples -> immediate IDLE, all outputs 0. A new start with num_samples=1 and input (0,7) -> acc=7, done=1.
6. In DONE (acc=39), assert start with num_samples=2 -> acc, sample_cnt, carry_cnt and overflow clear; busy=1. Then feed (1,0),(1,1) -> acc=33, carry_cnt=2.

Source files
------------

// File: rtl/rca_result_accumulator.sv
// Accumulates {cout,sum} results from the ripple-carry adder over a programmed
// number of samples. Define RCA_ACC_SATURATE_EN for a saturating accumulator.
module rca_result_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     sum,
  input  logic             cout,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // ACCUM | accepting adder results until the latched count is reached
  // DONE  | run complete, results held until the next start
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_carry_cnt;
  logic [CNT_W-1:0] r_num;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;
  logic             r_in_ready;

  logic [ACC_W:0]   w_acc_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_sample_inc;
  logic [CNT_W-1:0] w_carry_inc;
  logic             w_xfer;

  // One extra bit on the add exposes the carry out of the accumulator MSB.
  assign w_acc_sum    = {1'b0, r_acc} + {{(ACC_W-N){1'b0}}, cout, sum};
  assign w_sample_inc = r_sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_carry_inc  = r_carry_cnt + {{(CNT_W-1){1'b0}}, cout};
  assign w_xfer       = in_valid & r_in_ready;

`ifdef RCA_ACC_SATURATE_EN
  assign w_acc_next = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_acc_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_sample_cnt <= '0;
      r_carry_cnt  <= '0;
      r_num        <= '0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_acc        <= '0;
            r_sample_cnt <= '0;
            r_carry_cnt  <= '0;
            r_overflow   <= 1'b0;
            r_num        <= num_samples;
            if (num_samples != '0) begin
              r_state    <= ACCUM;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_in_ready <= 1'b1;
            end else begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_in_ready <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_acc        <= w_acc_next;
            r_sample_cnt <= w_sample_inc;
            r_carry_cnt  <= w_carry_inc;
            r_overflow   <= r_overflow | w_acc_sum[ACC_W];
            if (w_sample_inc == r_num) begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_in_ready <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign acc        = r_acc;
  assign sample_cnt = r_sample_cnt;
  assign carry_cnt  = r_carry_cnt;
  assign overflow   = r_overflow;
  assign busy       = r_busy;
  assign done       = r_done;
  assign in_ready   = r_in_ready;

endmodule

// File: tb/tb_rca_result_accumulator.sv
// Self-checking bench for rca_result_accumulator: directed plan cases plus
// randomized runs checked against an arithmetic model of the running sum.
module tb_rca_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sum;
  logic        cout;
  logic [11:0] acc;
  logic [7:0]  sample_cnt;
  logic [7:0]  carry_cnt;
  logic        overflow;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integer total, counts and programmed length.
  int m_total, m_samples, m_carries, m_num;
  logic [4:0] q[$];

  rca_result_accumulator #(.N(4), .ACC_W(12), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
    .acc(acc), .sample_cnt(sample_cnt), .carry_cnt(carry_cnt),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [31:0] status = {acc, sample_cnt, carry_cnt, overflow, done, busy, in_ready};

  function automatic logic [31:0] exp_status();
    logic [11:0] a;
    logic        d;
`ifdef RCA_ACC_SATURATE_EN
    a = (m_total > 4095) ? 12'hFFF : 12'(m_total);
`else
    a = 12'(m_total % 4096);
`endif
    d = (m_samples == m_num);
    return {a, 8'(m_samples), 8'(m_carries), (m_total > 4095), d, !d, !d};
  endfunction

  task automatic start_run(input int n);
    start = 1'b1;
    num_samples = 8'(n);
    @(negedge clk);
    start = 1'b0;
    m_total = 0; m_samples = 0; m_carries = 0; m_num = n;
    n_cmp++;
    if (status !== exp_status()) begin
      n_err++;
      $display("FAIL start_run(%0d): status got %h want %h", n, status, exp_status());
    end
  endtask

  // Feeds q; gap cycles of in_valid=0 between samples with garbage data.
  task automatic drive_samples(input int gap_max, input bit rnd);
    logic [4:0] v;
    int waitc, gap;
    while (q.size() > 0) begin
      v = q.pop_front();
      waitc = 0;
      while (!in_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (!in_ready) begin
        n_cmp++; n_err++;
        $display("FAIL ready_timeout: in_ready got %b want 1", in_ready);
        q.delete();
        return;
      end
      in_valid = 1'b1;
      {cout, sum} = v;
      if (rnd && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        num_samples = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b0;
      m_total += int'(v);
      m_samples++;
      m_carries += int'(v[4]);
      n_cmp++;
      if (status !== exp_status()) begin
        n_err++;
        $display("FAIL transfer %0d: status got %h want %h", m_samples, status, exp_status());
      end
      gap = rnd ? int'($urandom_range(0, gap_max)) : gap_max;
      repeat (gap) begin
        sum = 4'($urandom);
        cout = 1'($urandom);
        @(negedge clk);
        n_cmp++;
        if (status !== exp_status()) begin
          n_err++;
          $display("FAIL gap_hold: status got %h want %h", status, exp_status());
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0; sum = '0; cout = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (status !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: status got %h want 00000000", status);
    end
  endtask

  task automatic test_idle_valid();
    in_valid = 1'b1;
    repeat (5) begin
      sum = 4'($urandom); cout = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (status !== 32'h0) begin
        n_err++;
        $display("FAIL idle_valid: status got %h want 00000000", status);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    start_run(3);
    q = '{5'h05, 5'h13, 5'h0F};
    drive_samples(0, 1'b0);
    n_cmp++;
    if ({acc, sample_cnt, carry_cnt, overflow, done, in_ready} !== {12'd39, 8'd3, 8'd1, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL basic_final: acc=%0d cnt=%0d carry=%0d ovf=%b done=%b rdy=%b want 39 3 1 0 1 0",
               acc, sample_cnt, carry_cnt, overflow, done, in_ready);
    end
  endtask

  task automatic test_gaps();
    start_run(3);
    q = '{5'h05, 5'h13, 5'h0F};
    drive_samples(2, 1'b0);
    n_cmp++;
    if ({acc, sample_cnt, carry_cnt, overflow, done} !== {12'd39, 8'd3, 8'd1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL gaps_final: acc=%0d cnt=%0d carry=%0d ovf=%b done=%b want 39 3 1 0 1",
               acc, sample_cnt, carry_cnt, overflow, done);
    end
  endtask

  task automatic test_restart_from_done();
    start_run(2);
    n_cmp++;
    if ({acc, sample_cnt, carry_cnt, overflow, busy} !== {12'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL restart_clear: acc=%0d cnt=%0d carry=%0d ovf=%b busy=%b want 0 0 0 0 1",
               acc, sample_cnt, carry_cnt, overflow, busy);
    end
    q = '{5'h10, 5'h11};
    drive_samples(0, 1'b0);
    n_cmp++;
    if ({acc, carry_cnt, done} !== {12'd33, 8'd2, 1'b1}) begin
      n_err++;
      $display("FAIL restart_final: acc=%0d carry=%0d done=%b want 33 2 1", acc, carry_cnt, done);
    end
  endtask

  task automatic test_zero_samples();
    start_run(0);
    in_valid = 1'b1; sum = 4'hA; cout = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({acc, sample_cnt, done, busy, in_ready} !== {12'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL zero_samples: acc=%0d cnt=%0d done=%b busy=%b rdy=%b want 0 0 1 0 0",
               acc, sample_cnt, done, busy, in_ready);
    end
  endtask

  task automatic test_wrap();
    start_run(133);
    repeat (133) q.push_back(5'h1F);
    drive_samples(0, 1'b0);
    n_cmp++;
`ifdef RCA_ACC_SATURATE_EN
    if ({acc, overflow, carry_cnt, done} !== {12'd4095, 1'b1, 8'd133, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_final: acc=%0d ovf=%b carry=%0d done=%b want 4095 1 133 1", acc, overflow, carry_cnt, done);
    end
`else
    if ({acc, overflow, carry_cnt, done} !== {12'd27, 1'b1, 8'd133, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_final: acc=%0d ovf=%b carry=%0d done=%b want 27 1 133 1", acc, overflow, carry_cnt, done);
    end
`endif
  endtask

  task automatic test_reset_midrun();
    start_run(5);
    q = '{5'h09, 5'h1C};
    drive_samples(0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (status !== 32'h0) begin
      n_err++;
      $display("FAIL reset_midrun: status got %h want 00000000", status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(1);
    q = '{5'h07};
    drive_samples(0, 1'b0);
    n_cmp++;
    if ({acc, sample_cnt, done} !== {12'd7, 8'd1, 1'b1}) begin
      n_err++;
      $display("FAIL after_reset_run: acc=%0d cnt=%0d done=%b want 7 1 1", acc, sample_cnt, done);
    end
  endtask

  task automatic test_random();
    int n;
    repeat (25) begin
      n = int'($urandom_range(1, 20));
      start_run(n);
      repeat (n) q.push_back(5'($urandom));
      drive_samples(2, 1'b1);
    end
    // Long high-value runs to push the wrap/saturate path.
    repeat (3) begin
      n = int'($urandom_range(130, 200));
      start_run(n);
      repeat (n) q.push_back(5'($urandom_range(16, 31)));
      drive_samples(1, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_valid();
    test_basic();
    test_gaps();
    test_restart_from_done();
    test_zero_samples();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
